// File: rtl/mac_vec_if.sv
// AXI-Stream read-side channel feeding the vector MAC engine.
interface mac_vec_if #(
  parameter int unsigned DATA_WIDTH = 64
) ();
  logic                  tvalid;
  logic [DATA_WIDTH-1:0] tdata;
  logic                  tready;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/mac_vec.sv
// Vector multiply-accumulate over a programmed number of stream beats:
// per-lane terms -> registered adder tree -> saturating/wrapping accumulator.
module mac_vec #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned ELEM_W     = 16,
  parameter int unsigned ACC_W      = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rstn,
  mac_vec_if.slave         s_axis,
  input  logic             start,
  input  logic [CNT_W-1:0] nbeats,
  input  logic [1:0]       mode,
  input  logic             sat_en,
  output logic             busy,
  output logic             done,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [CNT_W-1:0] beat_cnt
);

  localparam int unsigned LANES  = DATA_WIDTH / ELEM_W;
  localparam int unsigned PROD_W = 2 * ELEM_W;
  localparam int unsigned TREE_W = PROD_W + $clog2(LANES);
  // Wide enough for acc + tree sum to be exact, so clamp direction is always right.
  localparam int unsigned SUM_W  = ((TREE_W > ACC_W) ? TREE_W : ACC_W) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]       state, state_next;
  logic [CNT_W-1:0] nbeats_q;
  logic [1:0]       mode_q;
  logic             sat_q;
  logic             tready_q;
  logic             v1, v2;
  logic             start_ok_c, accept_c, last_c;

  logic signed [ELEM_W-1:0] elem_c  [LANES];
  logic signed [PROD_W-1:0] terms_c [LANES];
  logic signed [PROD_W-1:0] terms_q [LANES];
  logic signed [TREE_W-1:0] tree_c, tree_q;
  logic signed [SUM_W-1:0]  sum_c;
  logic [SUM_W-ACC_W:0]     hi_c;
  logic                     ovf_c;
  logic [ACC_W-1:0]         acc_next_c;

  assign s_axis.tready = tready_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_next;
  end

  // Next-state and control strobes.
  always_comb begin
    state_next = state;
    start_ok_c = 1'b0;
    accept_c   = (state == S_RUN) && s_axis.tvalid && tready_q;
    last_c     = (beat_cnt == nbeats_q - CNT_W'(1));
    case (state)
      S_IDLE: begin
        if (start) begin
          start_ok_c = 1'b1;
          state_next = (nbeats == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN:   if (accept_c && last_c) state_next = S_DRAIN;
      // Stage 2 is absorbed on the same edge that leaves DRAIN.
      S_DRAIN: if (!v1) state_next = S_DONE;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Stage 1 term generation.
  always_comb begin
    for (int unsigned i = 0; i < LANES; i++) begin
      elem_c[i]  = $signed(s_axis.tdata[i*ELEM_W +: ELEM_W]);
      terms_c[i] = '0;
    end
    case (mode_q)
      2'd1: for (int unsigned k = 0; k < LANES/2; k++)
              terms_c[k] = PROD_W'(elem_c[2*k]) * PROD_W'(elem_c[2*k+1]);
      2'd2: for (int unsigned i = 0; i < LANES; i++)
              terms_c[i] = PROD_W'(elem_c[i]) * PROD_W'(elem_c[i]);
      default: for (int unsigned i = 0; i < LANES; i++)
              terms_c[i] = PROD_W'(elem_c[i]);
    endcase
  end

  always_comb begin
    tree_c = '0;
    for (int unsigned i = 0; i < LANES; i++)
      tree_c = tree_c + TREE_W'(terms_q[i]);
  end

  // Stage 3 add with overflow detection and optional clamp.
  always_comb begin
    sum_c = SUM_W'($signed(acc_out)) + SUM_W'(tree_q);
    hi_c  = sum_c[SUM_W-1:ACC_W-1];
    ovf_c = !((&hi_c) || !(|hi_c));
    if (ovf_c && sat_q)
      acc_next_c = sum_c[SUM_W-1] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    else
      acc_next_c = sum_c[ACC_W-1:0];
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      tready_q <= 1'b0;
      acc_out  <= '0;
      overflow <= 1'b0;
      beat_cnt <= '0;
      nbeats_q <= '0;
      mode_q   <= '0;
      sat_q    <= 1'b0;
      v1       <= 1'b0;
      v2       <= 1'b0;
      tree_q   <= '0;
      for (int unsigned i = 0; i < LANES; i++) terms_q[i] <= '0;
    end else begin
      busy <= (state_next == S_RUN) || (state_next == S_DRAIN);
      done <= (state_next == S_DONE);
      if (start_ok_c) begin
        nbeats_q <= nbeats;
        mode_q   <= mode;
        sat_q    <= sat_en;
        tready_q <= (nbeats != '0);
        acc_out  <= '0;
        overflow <= 1'b0;
        beat_cnt <= '0;
        v1       <= 1'b0;
        v2       <= 1'b0;
      end else begin
        if (accept_c) begin
          beat_cnt <= beat_cnt + CNT_W'(1);
          tready_q <= !last_c;
        end
        v1 <= accept_c;
        v2 <= v1;
        if (accept_c) terms_q <= terms_c;
        if (v1) tree_q <= tree_c;
        if (v2) begin
          acc_out <= acc_next_c;
          if (ovf_c) overflow <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_vec.sv
// Randomized self-checking bench for mac_vec against an arithmetic reference model.
module tb_mac_vec;

  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;

  logic        clk = 1'b0;
  logic        rstn;
  logic        start;
  logic [31:0] nbeats;
  logic [1:0]  mode;
  logic        sat_en;
  logic        busy, done, overflow;
  logic [31:0] acc_out, beat_cnt;

  int checks = 0;
  int errors = 0;
  logic [63:0] bq[$];

  mac_vec_if #(.DATA_WIDTH(64)) axis ();

  mac_vec #(.DATA_WIDTH(64), .ELEM_W(16), .ACC_W(32), .CNT_W(32)) dut (
    .clk(clk), .rstn(rstn), .s_axis(axis), .start(start), .nbeats(nbeats),
    .mode(mode), .sat_en(sat_en), .busy(busy), .done(done), .acc_out(acc_out),
    .overflow(overflow), .beat_cnt(beat_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] mk(input int a, input int b, input int c, input int d);
    return {16'(d), 16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic longint beat_value(input logic [63:0] w, input logic [1:0] m);
    longint e[4];
    for (int i = 0; i < 4; i++) e[i] = longint'($signed(w[i*16 +: 16]));
    case (m)
      2'd1:    return e[0]*e[1] + e[2]*e[3];
      2'd2:    return e[0]*e[0] + e[1]*e[1] + e[2]*e[2] + e[3]*e[3];
      default: return e[0] + e[1] + e[2] + e[3];
    endcase
  endfunction

  task automatic model_step(input logic [63:0] w, input logic [1:0] m, input logic s,
                            inout longint a, inout bit o);
    longint exact;
    exact = a + beat_value(w, m);
    if (exact > AMAX || exact < AMIN) begin
      o = 1'b1;
      if (s) a = (exact > 0) ? AMAX : AMIN;
      else   a = longint'(int'(exact));
    end else begin
      a = exact;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_tready"}, 64'(axis.tready), 64'(0));
    check({tag, "_busy"},   64'(busy),     64'(0));
    check({tag, "_done"},   64'(done),     64'(0));
    check({tag, "_acc"},    64'(acc_out),  64'(0));
    check({tag, "_ovf"},    64'(overflow), 64'(0));
    check({tag, "_cnt"},    64'(beat_cnt), 64'(0));
  endtask

  // One complete run driven from bq; the model only sees the first n beats.
  task automatic run(input int unsigned n, input logic [1:0] m, input logic s,
                     input int vpct, input bit restart);
    longint      acc_m = 0;
    bit          ovf_m = 1'b0;
    int unsigned got = 0;
    int          cyc = 0;
    logic        rdy;
    logic [31:0] exp_acc;
    for (int unsigned i = 0; i < n; i++) model_step(bq[i], m, s, acc_m, ovf_m);
    exp_acc = 32'(acc_m);
    start = 1'b1; nbeats = n; mode = m; sat_en = s;
    @(posedge clk); #1;
    start = 1'b0; nbeats = $urandom; mode = 2'($urandom); sat_en = 1'($urandom);
    if (n == 0) begin
      check("zero_done", 64'(done), 64'(1));
      check("zero_busy", 64'(busy), 64'(0));
      check("zero_tready", 64'(axis.tready), 64'(0));
      check("zero_acc", 64'(acc_out), 64'(0));
      @(posedge clk); #1;
      check("zero_done_end", 64'(done), 64'(0));
      return;
    end
    check("start_busy", 64'(busy), 64'(1));
    check("start_done", 64'(done), 64'(0));
    while (got < n) begin
      check("run_tready", 64'(axis.tready), 64'(1));
      check("run_cnt", 64'(beat_cnt), 64'(got));
      axis.tvalid = ($urandom_range(99) < vpct);
      axis.tdata  = bq[got];
      start = restart && (cyc == 1);
      rdy = axis.tready;
      @(posedge clk);
      if (axis.tvalid && rdy) got++;
      #1;
      cyc++;
      if (cyc > 2000) begin
        check("run_timeout", 64'(cyc), 64'(0));
        axis.tvalid = 1'b0; start = 1'b0;
        return;
      end
    end
    start = 1'b0;
    axis.tvalid = 1'b1;
    axis.tdata  = (bq.size() > n) ? bq[n] : 64'($urandom);
    check("l1_tready", 64'(axis.tready), 64'(0));
    check("l1_busy", 64'(busy), 64'(1));
    check("l1_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    check("l2_tready", 64'(axis.tready), 64'(0));
    check("l2_busy", 64'(busy), 64'(1));
    check("l2_done", 64'(done), 64'(0));
    @(posedge clk); #1;
    check("l3_done", 64'(done), 64'(1));
    check("l3_busy", 64'(busy), 64'(0));
    check("l3_acc", 64'(acc_out), 64'(exp_acc));
    check("l3_ovf", 64'(overflow), 64'(ovf_m));
    check("l3_cnt", 64'(beat_cnt), 64'(n));
    axis.tvalid = 1'b0;
    @(posedge clk); #1;
    check("hold_done", 64'(done), 64'(0));
    check("hold_acc", 64'(acc_out), 64'(exp_acc));
    check("hold_cnt", 64'(beat_cnt), 64'(n));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; start = 1'b0; nbeats = '0; mode = '0; sat_en = 1'b0;
    axis.tvalid = 1'b0; axis.tdata = '0;
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    check_idle_outputs("reset");

    bq = {mk(1,2,3,4), mk(1,2,3,4), mk(1,2,3,4)};
    run(3, 2'd0, 1'b0, 100, 1'b0);
    check("sum_30", 64'(acc_out), 64'(30));

    bq = {mk(3,-2,5,7), mk(3,-2,5,7)};
    run(2, 2'd1, 1'b0, 100, 1'b0);
    check("pair_58", 64'(acc_out), 64'(58));

    bq = {mk(-32768,-32768,-32768,-32768)};
    run(1, 2'd2, 1'b1, 100, 1'b0);
    check("sq_sat", 64'(acc_out), 64'h7FFF_FFFF);
    run(1, 2'd2, 1'b0, 100, 1'b0);
    check("sq_wrap", 64'(acc_out), 64'h0);
    check("sq_wrap_ovf", 64'(overflow), 64'(1));

    bq.delete();
    for (int i = 0; i < 6; i++)
      bq.push_back(mk($urandom_range(200) - 100, i, -i, 7));
    run(4, 2'd0, 1'b0, 50, 1'b0);

    bq = {mk(-1,-2,-3,-4), mk(5,5,5,5)};
    run(2, 2'd3, 1'b0, 70, 1'b0);

    run(0, 2'd0, 1'b0, 100, 1'b0);

    bq = {mk(10,20,30,40), mk(1,1,1,1), mk(-5,0,0,0)};
    run(3, 2'd0, 1'b0, 100, 1'b1);
    check("restart_acc", 64'(acc_out), 64'(99));

    // Abort after two of five beats, then a fresh single-beat run.
    bq = {mk(1,1,1,1), mk(2,2,2,2), mk(3,3,3,3), mk(4,4,4,4), mk(5,5,5,5)};
    start = 1'b1; nbeats = 5; mode = 2'd0; sat_en = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    axis.tvalid = 1'b1;
    for (int c = 0; c < 20 && beat_cnt != 2; c++) begin
      axis.tdata = bq[beat_cnt];
      @(posedge clk); #1;
    end
    check("abort_cnt", 64'(beat_cnt), 64'(2));
    rstn = 1'b0;
    #1;
    check_idle_outputs("abort");
    axis.tvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rstn = 1'b1;
    for (int c = 0; c < 4; c++) begin
      check("abort_no_done", 64'(done), 64'(0));
      @(posedge clk); #1;
    end
    bq = {mk(1,1,1,1)};
    run(1, 2'd0, 1'b0, 100, 1'b0);
    check("after_abort_acc", 64'(acc_out), 64'(4));

    for (int r = 0; r < 16; r++) begin
      int unsigned n;
      bit          big;
      n = $urandom_range(6, 1);
      big = 1'($urandom);
      bq.delete();
      for (int i = 0; i < n + 2; i++) begin
        if (big) bq.push_back({$urandom, $urandom});
        else     bq.push_back(mk($urandom_range(60) - 30, $urandom_range(60) - 30,
                                 $urandom_range(60) - 30, $urandom_range(60) - 30));
      end
      run(n, 2'($urandom), 1'($urandom), $urandom_range(100, 30), 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
